// File: rtl/peripheral_gpio_irq_pkg.sv
// Shared definitions for the APB4 GPIO peripheral: register indices,
// trigger encodings and the edge-arming counter width.
package peripheral_gpio_irq_pkg;

  localparam logic [3:0] GPIO_OE         = 4'd0;
  localparam logic [3:0] GPIO_OUT        = 4'd1;
  localparam logic [3:0] GPIO_IN         = 4'd2;
  localparam logic [3:0] GPIO_TRIG_TYPE  = 4'd3;
  localparam logic [3:0] GPIO_TRIG_POL   = 4'd4;
  localparam logic [3:0] GPIO_IRQ_EN     = 4'd5;
  localparam logic [3:0] GPIO_IRQ_STATUS = 4'd6;
  localparam logic [3:0] GPIO_REG_LAST   = GPIO_IRQ_STATUS;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_type_e;

  // Wide enough to hold SYNC_STAGES+1, the arming terminal count.
  function automatic int unsigned arm_cnt_width(input int unsigned sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/peripheral_gpio_sync_edge.sv
// Input synchroniser with one history flop and edge detection that stays
// disarmed for SYNC_STAGES+1 cycles after reset.
module peripheral_gpio_sync_edge
  import peripheral_gpio_irq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_c_o,
  output logic [WIDTH-1:0] fall_c_o
);

  localparam int unsigned     CNT_W    = arm_cnt_width(SYNC_STAGES);
  localparam logic [CNT_W-1:0] ARM_DONE = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CNT_W-1:0]                  arm_q;
  logic [CNT_W-1:0]                  arm_d;
  logic                              armed_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= arm_d;
    end
  end

  // Saturating arm counter; edges count only once the chain has refilled.
  always_comb begin
    armed_c = (arm_q == ARM_DONE);
    arm_d   = armed_c ? arm_q : arm_q + CNT_W'(1);
  end

  assign sync_o   = sync_q[SYNC_STAGES-1];
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q & {WIDTH{armed_c}};
  assign fall_c_o = ~sync_q[SYNC_STAGES-1] & prev_q & {WIDTH{armed_c}};

endmodule

// File: rtl/peripheral_gpio_irq_apb4.sv
// APB4 GPIO peripheral: per-pin output enable/value, synchronised inputs and
// level/edge interrupts latched in a W1C status register feeding irq_o.
module peripheral_gpio_irq_apb4
  import peripheral_gpio_irq_pkg::*;
#(
  parameter int unsigned PDATA_SIZE  = 8,
  parameter int unsigned PADDR_SIZE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe,
  output logic                    irq_o
);

  localparam int unsigned NUM_BYTES = PDATA_SIZE / 8;

  logic [3:0]            reg_idx;
  logic                  setup_c, access_c, idx_ok_c, wr_c;
  logic [PDATA_SIZE-1:0] strb_mask, rd_val, set_c, clr_c;
  logic [PDATA_SIZE-1:0] in_sync, edge_rise_c, edge_fall_c;

  logic [PDATA_SIZE-1:0] oe_q, oe_d, out_q, out_d, type_q, type_d;
  logic [PDATA_SIZE-1:0] pol_q, pol_d, en_q, en_d, stat_q, stat_d;
  logic [PDATA_SIZE-1:0] prdata_q, prdata_d;
  logic                  slverr_q, slverr_d, irq_q, irq_d;

  peripheral_gpio_sync_edge #(
    .WIDTH       (PDATA_SIZE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .d_i      (gpio_i),
    .sync_o   (in_sync),
    .rise_c_o (edge_rise_c),
    .fall_c_o (edge_fall_c)
  );

  assign reg_idx  = PADDR[3:0];
  assign setup_c  = PSEL & ~PENABLE;
  assign access_c = PSEL & PENABLE;
  assign idx_ok_c = (reg_idx <= GPIO_REG_LAST);
  assign wr_c     = access_c & PWRITE & idx_ok_c;

  always_comb begin
    strb_mask = '0;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      strb_mask[b*8 +: 8] = {8{PSTRB[b]}};
    end
  end

  always_comb begin
    oe_d     = oe_q;
    out_d    = out_q;
    type_d   = type_q;
    pol_d    = pol_q;
    en_d     = en_q;
    prdata_d = prdata_q;
    clr_c    = '0;

    // Edge pins follow the selected edge; level pins follow sync == polarity.
    set_c = (type_q & ((pol_q & edge_rise_c) | (~pol_q & edge_fall_c)))
          | (~type_q & ~(in_sync ^ pol_q));

    if (wr_c) begin
      case (reg_idx)
        GPIO_OE:         oe_d   = (oe_q   & ~strb_mask) | (PWDATA & strb_mask);
        GPIO_OUT:        out_d  = (out_q  & ~strb_mask) | (PWDATA & strb_mask);
        GPIO_TRIG_TYPE:  type_d = (type_q & ~strb_mask) | (PWDATA & strb_mask);
        GPIO_TRIG_POL:   pol_d  = (pol_q  & ~strb_mask) | (PWDATA & strb_mask);
        GPIO_IRQ_EN:     en_d   = (en_q   & ~strb_mask) | (PWDATA & strb_mask);
        GPIO_IRQ_STATUS: clr_c  = PWDATA & strb_mask;
        default:         ;
      endcase
    end

    // A new set in the same cycle as a clear keeps the bit.
    stat_d = (stat_q & ~clr_c) | set_c;

    case (reg_idx)
      GPIO_OE:         rd_val = oe_q;
      GPIO_OUT:        rd_val = out_q;
      GPIO_IN:         rd_val = in_sync;
      GPIO_TRIG_TYPE:  rd_val = type_q;
      GPIO_TRIG_POL:   rd_val = pol_q;
      GPIO_IRQ_EN:     rd_val = en_q;
      GPIO_IRQ_STATUS: rd_val = stat_q;
      default:         rd_val = '0;
    endcase

    // Read data and error are captured in setup so they are valid in access.
    if (setup_c && (!PWRITE || !idx_ok_c)) begin
      prdata_d = rd_val;
    end
    slverr_d = setup_c ? ~idx_ok_c : (access_c & slverr_q);
    irq_d    = |(stat_q & en_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      oe_q     <= '0;
      out_q    <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      en_q     <= '0;
      stat_q   <= '0;
      prdata_q <= '0;
      slverr_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      oe_q     <= oe_d;
      out_q    <= out_d;
      type_q   <= type_d;
      pol_q    <= pol_d;
      en_q     <= en_d;
      stat_q   <= stat_d;
      prdata_q <= prdata_d;
      slverr_q <= slverr_d;
      irq_q    <= irq_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = slverr_q;
  assign gpio_o  = out_q;
  assign gpio_oe = oe_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_peripheral_gpio_irq_apb4.sv
// Directed bench for the APB4 GPIO peripheral with a cycle-level behavioural
// model checked every cycle plus literal expectations on key scenarios.
module tb_peripheral_gpio_irq_apb4;
  import peripheral_gpio_irq_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned NB = DW / 8;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [NB-1:0] PSTRB = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] gpio_i = '0;
  logic [DW-1:0] PRDATA, gpio_o, gpio_oe;
  logic          PREADY, PSLVERR, irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  peripheral_gpio_irq_apb4 #(
    .PDATA_SIZE (DW),
    .PADDR_SIZE (AW),
    .SYNC_STAGES(S)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PSTRB   (PSTRB),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_oe, m_out, m_type, m_pol, m_en, m_stat, m_prdata;
  logic          m_irq;
  logic [DW-1:0] m_hist [0:S];   // m_hist[k] = gpio_i as sampled k+1 edges ago
  int            m_edges;        // clock edges seen since reset released
  bit            m_valid = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NB-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge PCLK) begin : model
    logic [DW-1:0] sync, prev, setv, clr, rd;
    logic [3:0]    idx;
    logic          armed;
    m_valid = 1'b1;
    if (PRESET) begin
      m_oe = '0; m_out = '0; m_type = '0; m_pol = '0; m_en = '0; m_stat = '0;
      m_prdata = '0; m_irq = 1'b0; m_edges = 0;
      for (int k = 0; k <= S; k++) m_hist[k] = '0;
    end else begin
      sync  = m_hist[S-1];
      prev  = m_hist[S];
      armed = (m_edges >= int'(S) + 1);
      for (int p = 0; p < DW; p++) begin
        if (m_type[p]) begin
          if (m_pol[p]) setv[p] = armed && sync[p] && !prev[p];
          else          setv[p] = armed && !sync[p] && prev[p];
        end else begin
          setv[p] = (sync[p] == m_pol[p]);
        end
      end
      idx = PADDR;
      case (idx)
        4'd0: rd = m_oe;
        4'd1: rd = m_out;
        4'd2: rd = sync;
        4'd3: rd = m_type;
        4'd4: rd = m_pol;
        4'd5: rd = m_en;
        4'd6: rd = m_stat;
        default: rd = '0;
      endcase
      m_irq = ((m_stat & m_en) != '0);
      if (PSEL && !PENABLE && (!PWRITE || idx > 4'd6)) m_prdata = rd;
      clr = '0;
      if (PSEL && PENABLE && PWRITE) begin
        case (idx)
          4'd0: m_oe   = merge(m_oe,   PWDATA, PSTRB);
          4'd1: m_out  = merge(m_out,  PWDATA, PSTRB);
          4'd3: m_type = merge(m_type, PWDATA, PSTRB);
          4'd4: m_pol  = merge(m_pol,  PWDATA, PSTRB);
          4'd5: m_en   = merge(m_en,   PWDATA, PSTRB);
          4'd6: clr    = merge('0,     PWDATA, PSTRB);
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr) | setv;
      for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = gpio_i;
      m_edges++;
    end
  end

  // Outputs are registered; compare on the falling edge while inputs are stable.
  always @(negedge PCLK) begin
    if (m_valid) begin
      check("gpio_o", gpio_o, m_out);
      check("gpio_oe", gpio_oe, m_oe);
      check("irq_o", DW'(irq_o), DW'(m_irq));
      check("PREADY", DW'(PREADY), DW'(1'b1));
      if (PSEL && PENABLE) begin
        check("PSLVERR", DW'(PSLVERR), DW'(PADDR > 4'd6));
        if (!PWRITE || PADDR > 4'd6) check("PRDATA", PRDATA, m_prdata);
      end
    end
  end

  // ---------------- driver (all changes at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [DW-1:0] d,
                           input logic [NB-1:0] st, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = st;
    tick(1);
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    tick(1);
    idle();
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [DW-1:0] d, output logic err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PSTRB = '0;
    tick(1);
    PENABLE = 1'b1;
    @(negedge PCLK);
    d   = PRDATA;
    err = PSLVERR;
    tick(1);
    idle();
  endtask

  logic [DW-1:0] rd;
  logic          err;

  initial begin
    tick(3);

    // Reset state: status is read in the very first cycle, before level-low sets it.
    PRESET = 1'b0;
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("reset_status", rd, 16'h0000);
    for (int r = 0; r < 6; r++) begin
      apb_read(4'(r), rd, err);
      check("reset_reg", rd, 16'h0000);
    end
    check("reset_gpio_o", gpio_o, 16'h0000);
    check("reset_gpio_oe", gpio_oe, 16'h0000);
    check("reset_irq", DW'(irq_o), 16'h0000);

    // Byte strobes
    apb_write(GPIO_OUT, 16'hA55A, 2'b01, err);
    check("strb_out", gpio_o, 16'h005A);
    apb_write(GPIO_OE, 16'hFFFF, 2'b11, err);
    check("strb_oe", gpio_oe, 16'hFFFF);

    // All pins rising-edge, clear status, enable bit 3
    apb_write(GPIO_TRIG_TYPE, 16'hFFFF, 2'b11, err);
    apb_write(GPIO_TRIG_POL, 16'hFFFF, 2'b11, err);
    apb_write(GPIO_IRQ_STATUS, 16'hFFFF, 2'b11, err);
    apb_write(GPIO_IRQ_EN, 16'h0008, 2'b11, err);
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("cleared_status", rd, 16'h0000);

    // Rising edge on bit 3: status after 3 edges, irq_o after 4
    gpio_i[3] = 1'b1;
    tick(3);
    check("irq_at_3", DW'(irq_o), 16'h0000);
    tick(1);
    check("irq_at_4", DW'(irq_o), 16'h0001);
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("rise_status", rd, 16'h0008);
    apb_write(GPIO_IRQ_STATUS, 16'h0008, 2'b11, err);
    check("irq_after_w1c_1", DW'(irq_o), 16'h0001);
    tick(1);
    check("irq_after_w1c_2", DW'(irq_o), 16'h0000);

    // Level-high on bit 0 re-asserts after W1C
    apb_write(GPIO_TRIG_TYPE, 16'hFFFE, 2'b11, err);
    gpio_i[0] = 1'b1;
    tick(4);
    apb_write(GPIO_IRQ_STATUS, 16'h0001, 2'b11, err);
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("level_reassert", rd, 16'h0001);

    // W1C lands on the same edge that latches a new rise on bit 5
    gpio_i[5] = 1'b1;
    tick(1);
    apb_write(GPIO_IRQ_STATUS, 16'h0020, 2'b11, err);
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("set_wins", rd, 16'h0021);

    // Invalid indices and read-only IN
    apb_read(4'd9, rd, err);
    check("bad_rd_data", rd, 16'h0000);
    check("bad_rd_err", DW'(err), 16'h0001);
    apb_read(4'd7, rd, err);
    check("idx7_err", DW'(err), 16'h0001);
    apb_write(4'd9, 16'hFFFF, 2'b11, err);
    check("bad_wr_err", DW'(err), 16'h0001);
    apb_read(GPIO_OUT, rd, err);
    check("out_unchanged", rd, 16'h005A);
    check("good_rd_err", DW'(err), 16'h0000);
    apb_write(GPIO_IN, 16'hFFFF, 2'b11, err);
    check("in_wr_err", DW'(err), 16'h0000);
    apb_read(GPIO_IN, rd, err);
    check("in_value", rd, 16'h0029);

    // Reset during the access phase of a write to OUT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = GPIO_OUT; PWDATA = 16'hFFFF; PSTRB = 2'b11;
    tick(1);
    PENABLE = 1'b1; PRESET = 1'b1;
    tick(1);
    idle(); PRESET = 1'b0;
    apb_read(GPIO_OUT, rd, err);
    check("reset_abort_out", rd, 16'h0000);

    // Pins held high through reset, then all-rising edge mode
    gpio_i = 16'hFFFF;
    PRESET = 1'b1;
    tick(3);
    PRESET = 1'b0;
    apb_write(GPIO_TRIG_TYPE, 16'hFFFF, 2'b11, err);
    apb_write(GPIO_TRIG_POL, 16'hFFFF, 2'b11, err);
    apb_write(GPIO_IRQ_STATUS, 16'hFFFF, 2'b11, err);
    tick(5);
    apb_read(GPIO_IRQ_STATUS, rd, err);
    check("arm_status", rd, 16'h0000);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
